mdu_sequencer: RTL



---
 rtl/mdu_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mdu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_sequencer
//
// Multi-cycle multiply/divide controller beside the ALU in EX. It accepts
// one MDU op per start pulse, owns HI/LO, models a fixed multiply/divide
// latency, and raises the D-stage stall request while an operation is in
// flight. The mf read path (o_result) feeds the MDU writeback mux.
//
// Optional feature macro: MDU_CANCEL_EN
//   Defined   -> i_cancel aborts an in-flight op. HI/LO keep their old value.
//   Undefined -> i_cancel is ignored. Every accepted op completes.
//
// MDU op encoding (i_mduOp):
//   0 DEFAULT, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (1..255)
//   DIV_CYCLES   busy cycles for div/divu   (1..255)
//
// Ports:
//   i_clk      clock, rising edge
//   i_reset    asynchronous active-high reset
//   i_start    EX-stage instruction is an MDU op
//   i_mduOp    MDU op code
//   i_rs_data  rs operand (dividend / multiplicand / mt source)
//   i_rt_data  rt operand (divisor / multiplier)
//   i_d_mdu    D-stage instruction is an MDU op
//   i_cancel   abort in-flight op (MDU_CANCEL_EN only)
//   o_busy     operation in flight
//   o_stall    stall request to D stage
//   o_result   HI for MFHI, LO for MFLO, else 0
//   o_hi       current HI
//   o_lo       current LO
// ---------------------------------------------------------------------------
module mdu_sequencer #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [4:0]  i_mduOp,
   input  logic [31:0] i_rs_data,
   input  logic [31:0] i_rt_data,
   input  logic        i_d_mdu,
   input  logic        i_cancel,
   output logic        o_busy,
   output logic        o_stall,
   output logic [31:0] o_result,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo
);

   localparam logic [4:0] MDU_DEFAULT = 5'd0;
   localparam logic [4:0] MDU_MULT    = 5'd1;
   localparam logic [4:0] MDU_MULTU   = 5'd2;
   localparam logic [4:0] MDU_DIV     = 5'd3;
   localparam logic [4:0] MDU_DIVU    = 5'd4;
   localparam logic [4:0] MDU_MTHI    = 5'd5;
   localparam logic [4:0] MDU_MTLO    = 5'd6;
   localparam logic [4:0] MDU_MFHI    = 5'd7;
   localparam logic [4:0] MDU_MFLO    = 5'd8;

   localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES);
   localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t      state, state_nx;
   logic [7:0]  cnt, cnt_nx;
   logic [31:0] hi, hi_nx, lo, lo_nx;
   logic [31:0] res_hi, res_hi_nx, res_lo, res_lo_nx;

   logic        cancel;
   logic        busy;
   logic        done;
   logic        accept;
   logic        is_md;

   logic [63:0] prod_s, prod_u;
   logic        div_signed, div_zero;
   logic [31:0] mag_a, mag_b, uq, ur, quot, rem;

`ifdef MDU_CANCEL_EN
   assign cancel = i_cancel;
`else
   logic unused_cancel;
   assign unused_cancel = i_cancel;
   assign cancel        = 1'b0;
`endif

   assign busy  = (state != IDLE);
   assign is_md = (i_mduOp == MDU_MULT) || (i_mduOp == MDU_MULTU) ||
                  (i_mduOp == MDU_DIV)  || (i_mduOp == MDU_DIVU);

   // The final busy edge also accepts a new op, so back-to-back md ops keep
   // o_busy high with no idle gap. Cancel beats both completion and start.
   assign done   = busy && (cnt == 8'd1) && !cancel;
   assign accept = i_start && !cancel && ((state == IDLE) || done);

   // Products and quotients are computed at accept time. The counter only
   // models latency.
   always_comb begin
      prod_s = {{32{i_rs_data[31]}}, i_rs_data} * {{32{i_rt_data[31]}}, i_rt_data};
      prod_u = {32'd0, i_rs_data} * {32'd0, i_rt_data};

      // Signed divide is done on magnitudes and the signs are fixed up after.
      // This gives truncation toward zero and a remainder with the dividend's
      // sign. It also gives 0x80000000 / -1 = 0x80000000 with no special case.
      div_signed = (i_mduOp == MDU_DIV);
      div_zero   = (i_rt_data == 32'd0);
      mag_a = (div_signed && i_rs_data[31]) ? (32'd0 - i_rs_data) : i_rs_data;
      mag_b = (div_signed && i_rt_data[31]) ? (32'd0 - i_rt_data) : i_rt_data;
      uq    = div_zero ? 32'd0 : (mag_a / mag_b);
      ur    = div_zero ? 32'd0 : (mag_a % mag_b);
      quot  = (div_signed && (i_rs_data[31] ^ i_rt_data[31])) ? (32'd0 - uq) : uq;
      rem   = (div_signed && i_rs_data[31]) ? (32'd0 - ur) : ur;
   end

   // NOTE: every variable assigned here gets a default first, so no path can
   // infer a latch.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      hi_nx     = hi;
      lo_nx     = lo;
      res_hi_nx = res_hi;
      res_lo_nx = res_lo;

      case (state)
         IDLE: ;
         MUL, DIV: begin
            if (cancel) begin
               state_nx = IDLE;
               cnt_nx   = 8'd0;
            end else if (cnt == 8'd1) begin
               hi_nx    = res_hi;
               lo_nx    = res_lo;
               state_nx = IDLE;
               cnt_nx   = 8'd0;
            end else begin
               cnt_nx = cnt - 8'd1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = 8'd0;
         end
      endcase

      if (accept) begin
         case (i_mduOp)
            MDU_MULT: begin
               {res_hi_nx, res_lo_nx} = prod_s;
               cnt_nx   = MULT_LOAD;
               state_nx = MUL;
            end
            MDU_MULTU: begin
               {res_hi_nx, res_lo_nx} = prod_u;
               cnt_nx   = MULT_LOAD;
               state_nx = MUL;
            end
            MDU_DIV, MDU_DIVU: begin
               // A zero divisor re-commits the current HI/LO. The latency
               // stays the same and the visible result is unchanged.
               if (div_zero) begin
                  res_hi_nx = hi_nx;
                  res_lo_nx = lo_nx;
               end else begin
                  res_hi_nx = rem;
                  res_lo_nx = quot;
               end
               cnt_nx   = DIV_LOAD;
               state_nx = DIV;
            end
            MDU_MTHI: hi_nx = i_rs_data;
            MDU_MTLO: lo_nx = i_rs_data;
            MDU_MFHI, MDU_MFLO, MDU_DEFAULT: ;
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only. Every
   // register reads its old value at the same edge, whatever the code order.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state  <= IDLE;
         cnt    <= 8'd0;
         hi     <= 32'd0;
         lo     <= 32'd0;
         res_hi <= 32'd0;
         res_lo <= 32'd0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         hi     <= hi_nx;
         lo     <= lo_nx;
         res_hi <= res_hi_nx;
         res_lo <= res_lo_nx;
      end
   end

   assign o_busy  = busy;
   assign o_stall = i_d_mdu & (busy | (i_start & is_md));
   assign o_hi    = hi;
   assign o_lo    = lo;

   always_comb begin
      case (i_mduOp)
         MDU_MFHI: o_result = hi;
         MDU_MFLO: o_result = lo;
         default:  o_result = 32'd0;
      endcase
   end

endmodule
